// File: rtl/phys_cache_pkg.sv
// Shared types and address-decoding helpers for the physical-side cache.
package phys_cache_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_BITS    = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_FILL_GAP = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4,
        ST_RELEASE  = 3'd5
    } state_e;

    function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [31:0] addr);
        return addr[OFFSET_BITS+1:2];
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned index_bits);
        return (addr >> (OFFSET_BITS + 2)) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned index_bits);
        return addr >> (index_bits + OFFSET_BITS + 2);
    endfunction

endpackage

// File: rtl/phys_cache_array.sv
// Tag, valid and data storage: combinational read, single-word write, one-cycle flush of all valid bits.
module phys_cache_array
    import phys_cache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic [INDEX_BITS-1:0]  rd_index_i,
    input  logic [OFFSET_BITS-1:0] rd_offset_i,
    output logic                   rd_valid_o,
    output logic [TAG_BITS-1:0]    rd_tag_o,
    output logic [31:0]            rd_word_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_BITS-1:0]  wr_index_i,
    input  logic [OFFSET_BITS-1:0] wr_offset_i,
    input  logic [31:0]            wr_word_i,
    input  logic                   set_valid_i,
    input  logic [TAG_BITS-1:0]    set_tag_i
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES*WORDS_PER_LINE];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_word_o  = data_q[{rd_index_i, rd_offset_i}];

    // Valid bits; a flush wins over a line being marked valid on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (set_valid_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data storage, never reset.
    always_ff @(posedge clk) begin
        if (set_valid_i) begin
            tag_q[wr_index_i] <= set_tag_i;
        end
        if (wr_en_i) begin
            data_q[{wr_index_i, wr_offset_i}] <= wr_word_i;
        end
    end

endmodule

// File: rtl/phys_cache.sv
// Direct-mapped write-through, no-write-allocate cache between MMU and memory bus.
// Define PHYS_CACHE_STATS_EN to add hit_cnt_o/miss_cnt_o read counters.
module phys_cache
    import phys_cache_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        we_i,
    input  logic        rd_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    input  logic        flush_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    output logic        mem_we_o,
    output logic        mem_rd_o,
    input  logic        mem_ack_i
`ifdef PHYS_CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int TAG_BITS = 32 - INDEX_BITS - 4;

    state_e                 state_q;
    logic [31:0]            req_addr_q;
    logic [1:0]             k_q;
    logic                   flushed_q;
    logic                   wr_hit_q;
    logic [31:0]            rdata_q;
    logic                   ack_q;
    logic [31:0]            data_q;
    logic [31:0]            mem_addr_q;
    logic [31:0]            mem_data_q;
    logic                   mem_rd_q;
    logic                   mem_we_q;

    logic                   rd_valid_s;
    logic [TAG_BITS-1:0]    rd_tag_s;
    logic [31:0]            rd_word_s;
    logic                   hit_s;
    logic                   wr_en_s;
    logic [OFFSET_BITS-1:0] wr_offset_s;
    logic [31:0]            wr_word_s;
    logic                   set_valid_s;

    phys_cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .rd_index_i  (INDEX_BITS'(addr_index(addr_i, INDEX_BITS))),
        .rd_offset_i (addr_offset(addr_i)),
        .rd_valid_o  (rd_valid_s),
        .rd_tag_o    (rd_tag_s),
        .rd_word_o   (rd_word_s),
        .wr_en_i     (wr_en_s),
        .wr_index_i  (INDEX_BITS'(addr_index(req_addr_q, INDEX_BITS))),
        .wr_offset_i (wr_offset_s),
        .wr_word_i   (wr_word_s),
        .set_valid_i (set_valid_s),
        .set_tag_i   (TAG_BITS'(addr_tag(req_addr_q, INDEX_BITS)))
    );

    assign hit_s       = rd_valid_s && (rd_tag_s == TAG_BITS'(addr_tag(addr_i, INDEX_BITS)));
    assign set_valid_s = (state_q == ST_FILL_GAP) && (k_q == 2'd3) && !flushed_q;

    // Array write port: refill words during FILL, write-through update on a write hit.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_offset_s = addr_offset(req_addr_q);
        wr_word_s   = mem_data_q;
        if (state_q == ST_FILL) begin
            wr_en_s     = mem_ack_i;
            wr_offset_s = k_q;
            wr_word_s   = mem_data_i;
        end else if (state_q == ST_WRITE) begin
            wr_en_s = mem_ack_i && wr_hit_q;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Request sequencing and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            req_addr_q <= 32'd0;
            k_q        <= 2'd0;
            flushed_q  <= 1'b0;
            wr_hit_q   <= 1'b0;
            rdata_q    <= 32'd0;
            ack_q      <= 1'b0;
            data_q     <= 32'd0;
            mem_addr_q <= 32'd0;
            mem_data_q <= 32'd0;
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (we_i) begin
                        req_addr_q <= addr_i;
                        wr_hit_q   <= hit_s;
                        mem_addr_q <= {addr_i[31:2], 2'b00};
                        mem_data_q <= data_i;
                        mem_we_q   <= 1'b1;
                        state_q    <= ST_WRITE;
                    end else if (rd_i) begin
                        req_addr_q <= addr_i;
                        if (hit_s) begin
                            rdata_q <= rd_word_s;
                            state_q <= ST_RESP;
                        end else begin
                            k_q        <= 2'd0;
                            flushed_q  <= 1'b0;
                            mem_addr_q <= {addr_i[31:4], 2'b00, 2'b00};
                            mem_rd_q   <= 1'b1;
                            state_q    <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (flush_i) begin
                        flushed_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        mem_rd_q <= 1'b0;
                        if (k_q == addr_offset(req_addr_q)) begin
                            rdata_q <= mem_data_i;
                        end
                        state_q <= ST_FILL_GAP;
                    end
                end
                ST_FILL_GAP: begin
                    if (flush_i) begin
                        flushed_q <= 1'b1;
                    end
                    if (k_q != 2'd3) begin
                        k_q        <= k_q + 2'd1;
                        mem_addr_q <= {req_addr_q[31:4], k_q + 2'd1, 2'b00};
                        mem_rd_q   <= 1'b1;
                        state_q    <= ST_FILL;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    if (mem_ack_i) begin
                        mem_we_q <= 1'b0;
                        rdata_q  <= 32'd0;
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ack_q   <= 1'b1;
                    data_q  <= rdata_q;
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    ack_q <= 1'b0;
                    if (!rd_i && !we_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o      = ack_q;
    assign data_o     = data_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_rd_o   = mem_rd_q;
    assign mem_we_o   = mem_we_q;

`ifdef PHYS_CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Each read is counted once, at the moment IDLE decides hit or miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if ((state_q == ST_IDLE) && !we_i && rd_i) begin
            if (hit_s) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_phys_cache.sv
// Self-checking bench for phys_cache: memory responder plus an abstract cache/memory reference model.
module tb_phys_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i, data_i, data_o, mem_addr_o, mem_data_o, mem_data_i;
    logic        we_i, rd_i, ack_o, flush_i, mem_we_o, mem_rd_o, mem_ack_i;
`ifdef PHYS_CACHE_STATS_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

    phys_cache #(.INDEX_BITS(4)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .we_i(we_i), .rd_i(rd_i),
        .data_o(data_o), .ack_o(ack_o), .flush_i(flush_i), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_we_o(mem_we_o),
        .mem_rd_o(mem_rd_o), .mem_ack_i(mem_ack_i)
`ifdef PHYS_CACHE_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int bus_viol = 0;
    bit spurious = 1'b0;

    logic [31:0] log_addr[$];
    bit          log_we[$];
    logic [31:0] log_data[$];
    logic [31:0] mem_m[logic [31:0]];

    // reference cache state: which lines hold which tag
    bit          mv[16];
    logic [31:0] mt[16];
    int          m_hits = 0;
    int          m_miss = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'hA5A50000;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 4) % 32'd16);
    endfunction

    function automatic logic [31:0] m_tag(input logic [31:0] a);
        return a >> 8;
    endfunction

    task automatic model_flush();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    // Memory responder and bus monitor, acting on falling edges.
    initial begin
        int dly = 0;
        int lat = 1;
        mem_ack_i  = 1'b0;
        mem_data_i = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_rd_o && mem_we_o) bus_viol++;
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                if (mem_rd_o || mem_we_o) bus_viol++;
            end else if (spurious) begin
                mem_ack_i  = 1'b1;
                mem_data_i = 32'hDEADBEEF;
                spurious   = 1'b0;
            end else if (rst && (mem_rd_o || mem_we_o)) begin
                if (dly < lat) begin
                    dly++;
                end else begin
                    dly = 0;
                    lat = $urandom_range(1, 3);
                    mem_ack_i = 1'b1;
                    log_addr.push_back(mem_addr_o);
                    log_we.push_back(mem_we_o);
                    log_data.push_back(mem_we_o ? mem_data_o : 32'd0);
                    if (mem_we_o) mem_m[mem_addr_o] = mem_data_o;
                    else          mem_data_i = mem_val(mem_addr_o);
                end
            end else begin
                dly = 0;
            end
            if (ack_o) ack_cnt++;
        end
    end

    task automatic pulse_flush();
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        model_flush();
    endtask

    task automatic do_read(input logic [31:0] a, input bit with_flush);
        int base = log_addr.size();
        int acks0 = ack_cnt;
        int cyc = 0;
        bit done = 1'b0;
        bit exp_hit = mv[m_idx(a)] && (mt[m_idx(a)] == m_tag(a));
        bit fl = with_flush && exp_hit;
        logic [31:0] exp_d = mem_val(a & ~32'd3);
        logic [31:0] got;
        int nrd;
        addr_i = a;
        rd_i = 1'b1;
        flush_i = fl;
        while (!done && cyc < 300) begin
            @(negedge clk);
            flush_i = 1'b0;
            cyc++;
            if (ack_o) done = 1'b1;
        end
        got = data_o;
        rd_i = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL read_timeout addr=%h cycles=%0d required ack within 300", a, cyc);
        end
        checks++;
        if (got !== exp_d) begin
            errors++;
            $display("FAIL read_data addr=%h got=%h required=%h", a, got, exp_d);
        end
        if (exp_hit) begin
            checks++;
            if (cyc != 2) begin
                errors++;
                $display("FAIL hit_latency addr=%h got=%0d required=2", a, cyc);
            end
        end
        @(negedge clk);
        checks++;
        if (ack_o !== 1'b0 || ack_cnt - acks0 != 1) begin
            errors++;
            $display("FAIL read_ack_pulse addr=%h acks=%0d ack_now=%b required 1 pulse", a, ack_cnt - acks0, ack_o);
        end
        nrd = log_addr.size() - base;
        checks++;
        if (nrd != (exp_hit ? 0 : 4)) begin
            errors++;
            $display("FAIL mem_read_count addr=%h got=%0d required=%0d", a, nrd, exp_hit ? 0 : 4);
        end else if (!exp_hit) begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] ea = (a & ~32'd15) + 32'(4 * i);
                checks++;
                if (log_addr[base+i] !== ea || log_we[base+i] !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_addr word=%0d got=%h we=%b required=%h", i, log_addr[base+i], log_we[base+i], ea);
                end
            end
        end
        if (exp_hit) begin
            m_hits++;
        end else begin
            m_miss++;
            mv[m_idx(a)] = 1'b1;
            mt[m_idx(a)] = m_tag(a);
        end
        if (fl) model_flush();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int base = log_addr.size();
        int acks0 = ack_cnt;
        int cyc = 0;
        bit done = 1'b0;
        logic [31:0] got;
        addr_i = a;
        data_i = d;
        we_i = 1'b1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (ack_o) done = 1'b1;
        end
        got = data_o;
        we_i = 1'b0;
        @(negedge clk);
        checks++;
        if (!done || got !== 32'd0 || ack_cnt - acks0 != 1) begin
            errors++;
            $display("FAIL write_resp addr=%h done=%b data=%h acks=%0d required data=0 acks=1", a, done, got, ack_cnt - acks0);
        end
        checks++;
        if (log_addr.size() - base != 1) begin
            errors++;
            $display("FAIL write_count addr=%h got=%0d required=1", a, log_addr.size() - base);
        end else if (log_addr[base] !== (a & ~32'd3) || log_we[base] !== 1'b1 || log_data[base] !== d) begin
            errors++;
            $display("FAIL write_bus got addr=%h we=%b data=%h required addr=%h data=%h",
                     log_addr[base], log_we[base], log_data[base], a & ~32'd3, d);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ack_o, mem_rd_o, mem_we_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got ack/rd/we=%b required=000", {ack_o, mem_rd_o, mem_we_o});
        end
        checks++;
        if (data_o !== 32'd0 || mem_addr_o !== 32'd0 || mem_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got data=%h maddr=%h mdata=%h required 0", data_o, mem_addr_o, mem_data_o);
        end
`ifdef PHYS_CACHE_STATS_EN
        checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats got hit=%0d miss=%0d required 0/0", hit_cnt_o, miss_cnt_o);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_and_hits();
        do_read(32'h0000_1004, 1'b0);
        do_read(32'h0000_1000, 1'b0);
        do_read(32'h0000_1008, 1'b0);
        do_read(32'h0000_100C, 1'b0);
    endtask

    task automatic test_spurious_ack();
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        do_read(32'h0000_1004, 1'b0);
    endtask

    task automatic test_write();
        do_write(32'h0000_1008, 32'h0123_4567);
        do_read(32'h0000_1008, 1'b0);
        do_write(32'h0000_2000, 32'h89AB_CDEF);
        do_read(32'h0000_2000, 1'b0);
    endtask

    task automatic test_conflict();
        int base;
        pulse_flush();
        base = log_addr.size();
        do_read(32'h0000_1000, 1'b0);
        do_read(32'h0000_1100, 1'b0);
        do_read(32'h0000_1000, 1'b0);
        checks++;
        if (log_addr.size() - base != 12) begin
            errors++;
            $display("FAIL conflict_reads got=%0d required=12", log_addr.size() - base);
        end
    endtask

    task automatic test_flush_hit();
        do_read(32'h0000_1000, 1'b1);
        do_read(32'h0000_1000, 1'b0);
    endtask

    task automatic test_flush_fill();
        logic [31:0] a = 32'h0000_3000;
        logic [31:0] exp_d = mem_val(a);
        logic [31:0] got;
        int base = log_addr.size();
        int acks0 = ack_cnt;
        int cyc = 0;
        bit done = 1'b0;
        bit flushed = 1'b0;
        addr_i = a;
        rd_i = 1'b1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            flush_i = 1'b0;
            if (!flushed && log_addr.size() == base + 2 && mem_rd_o) begin
                flush_i = 1'b1;
                flushed = 1'b1;
            end
            if (ack_o) done = 1'b1;
        end
        got = data_o;
        rd_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (!done || !flushed || got !== exp_d || ack_cnt - acks0 != 1 || log_addr.size() - base != 4) begin
            errors++;
            $display("FAIL flush_fill done=%b flushed=%b data=%h required=%h acks=%0d reads=%0d",
                     done, flushed, got, exp_d, ack_cnt - acks0, log_addr.size() - base);
        end
        m_miss++;
        model_flush();
        do_read(a, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int r = $urandom_range(0, 9);
            logic [31:0] a = 32'h4000 + 32'($urandom_range(0, 2)) * 32'h100 + 32'($urandom_range(0, 3)) * 32'h10
                             + 32'($urandom_range(0, 3)) * 32'h4 + 32'($urandom_range(0, 3));
            if (r < 7) do_read(a, r == 0);
            else       do_write(a, $urandom);
        end
`ifdef PHYS_CACHE_STATS_EN
        checks++;
        if (hit_cnt_o !== 32'(m_hits) || miss_cnt_o !== 32'(m_miss)) begin
            errors++;
            $display("FAIL random_stats got hit=%0d miss=%0d required %0d/%0d", hit_cnt_o, miss_cnt_o, m_hits, m_miss);
        end
`endif
    endtask

    task automatic test_reset_mid_fill();
        int base;
        int acks0;
        int cyc = 0;
        bit bad = 1'b0;
        pulse_flush();
        base = log_addr.size();
        addr_i = 32'h0000_1000;
        rd_i = 1'b1;
        while (log_addr.size() < base + 2 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        acks0 = ack_cnt;
        rst = 1'b0;
        rd_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack_o || mem_rd_o || mem_we_o) bad = 1'b1;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bad || ack_cnt != acks0 || cyc >= 300) begin
            errors++;
            $display("FAIL reset_abort bad=%b acks=%0d required 0 cycles=%0d", bad, ack_cnt - acks0, cyc);
        end
        model_flush();
        m_hits = 0;
        m_miss = 0;
        do_read(32'h0000_1000, 1'b0);
`ifdef PHYS_CACHE_STATS_EN
        checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL reset_stats_after got hit=%0d miss=%0d required 0/1", hit_cnt_o, miss_cnt_o);
        end
`endif
    endtask

    task automatic test_bus_rule();
        checks++;
        if (bus_viol != 0) begin
            errors++;
            $display("FAIL bus_rule got violations=%0d required=0", bus_viol);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        addr_i = 32'd0;
        data_i = 32'd0;
        we_i = 1'b0;
        rd_i = 1'b0;
        flush_i = 1'b0;
        model_flush();
        repeat (3) @(negedge clk);
        test_reset();
        test_cold_and_hits();
        test_spurious_ack();
        test_write();
        test_conflict();
        test_flush_hit();
        test_flush_fill();
        test_random();
        test_reset_mid_fill();
        test_bus_rule();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
